mem_access_stage: RTL and testbench

- MEM-stage load/store unit. Sits between the EX/MEM pipeline register and the MEM/WB register.
- Drives a request/acknowledge data-memory port and performs byte-lane steering and load sign/zero extension.
- Stalls the pipeline while an access is outstanding.
- Its readdata_out feeds MEM/WB readdata_in.

---
 rtl/mem_access_stage_if.sv | 30 +++
 rtl/mem_access_stage.sv | 219 +++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge port between the MEM-stage load/store unit and memory.
interface mem_access_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_be,
        output dmem_wdata,
        input  dmem_ack,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_be,
        input  dmem_wdata,
        output dmem_ack,
        output dmem_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM-stage load/store unit: issues one data-memory access per instruction, steers byte lanes,
// extends loads and stalls the pipeline while busy. Optional: MISALIGN_TRAP_EN traps misaligned accesses.
module mem_access_stage #(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned CNT_W    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       valid_in,
    input  logic                       memread_in,
    input  logic                       memwrite_in,
    input  logic [2:0]                 funct3_in,
    input  logic [31:0]                addr_in,
    input  logic [31:0]                wdata_in,
    mem_access_stage_if.master         dmem,
    output logic [31:0]                readdata_out,
    output logic                       stall,
    output logic                       mem_err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              load_q, load_d;
    size_t             size_q, size_d;
    logic              sext_q, sext_d;
    logic [1:0]        lane_q, lane_d;
    logic              stall_c;

    // Request decode from the EX/MEM slot
    size_t       size_c;
    logic [1:0]  lane_c;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic        access_c;
    logic        issue_ok_c;
    logic [CNT_W-1:0] cnt_inc_c;
    logic        timeout_c;

    always_comb begin
        case (funct3_in)
            3'b000, 3'b100: size_c = SZ_B;
            3'b001, 3'b101: size_c = SZ_H;
            default:        size_c = SZ_W;
        endcase
    end

    // Low address bits are forced to the natural alignment of the access size
    always_comb begin
        lane_c  = 2'b00;
        be_c    = 4'b1111;
        wdata_c = wdata_in;
        case (size_c)
            SZ_B: begin
                lane_c  = addr_in[1:0];
                be_c    = 4'b0001 << lane_c;
                wdata_c = {4{wdata_in[7:0]}};
            end
            SZ_H: begin
                lane_c  = {addr_in[1], 1'b0};
                be_c    = 4'b0011 << lane_c;
                wdata_c = {2{wdata_in[15:0]}};
            end
            default: begin
                lane_c  = 2'b00;
                be_c    = 4'b1111;
                wdata_c = wdata_in;
            end
        endcase
    end

    assign access_c = valid_in & (memread_in | memwrite_in);

`ifdef MISALIGN_TRAP_EN
    logic misaligned_c;
    assign misaligned_c = ((size_c == SZ_H) && addr_in[0]) ||
                          ((size_c == SZ_W) && (addr_in[1:0] != 2'b00));
    assign issue_ok_c   = ~misaligned_c;
`else
    assign issue_ok_c   = 1'b1;
`endif

    assign cnt_inc_c = cnt_q + CNT_W'(1);
    assign timeout_c = (cnt_inc_c == CNT_W'(MAX_WAIT));

    function automatic logic [31:0] load_extend(input size_t sz, input logic sx,
                                                input logic [1:0] ln, input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (ln)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = ln[1] ? w[31:16] : w[15:0];
        case (sz)
            SZ_B:    load_extend = sx ? {{24{b[7]}}, b} : {24'h0, b};
            SZ_H:    load_extend = sx ? {{16{h[15]}}, h} : {16'h0, h};
            default: load_extend = w;
        endcase
    endfunction

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        load_d  = load_q;
        size_d  = size_q;
        sext_d  = sext_q;
        lane_d  = lane_q;
        stall_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (access_c && issue_ok_c) begin
                    stall_c = 1'b1;
                    req_d   = 1'b1;
                    we_d    = memwrite_in;
                    addr_d  = {addr_in[31:2], 2'b00};
                    be_d    = be_c;
                    wdata_d = wdata_c;
                    load_d  = ~memwrite_in;
                    size_d  = size_c;
                    sext_d  = ~funct3_in[2];
                    lane_d  = lane_c;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
`ifdef MISALIGN_TRAP_EN
                else if (access_c) begin
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                end
`endif
            end
            BUSY: begin
                stall_c = 1'b1;
                if (dmem.dmem_ack) begin
                    req_d   = 1'b0;
                    if (load_q)
                        rdata_d = load_extend(size_q, sext_q, lane_q, dmem.dmem_rdata);
                    state_d = DONE;
                end else if (timeout_c) begin
                    req_d   = 1'b0;
                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_inc_c;
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            load_q  <= 1'b0;
            size_q  <= SZ_W;
            sext_q  <= 1'b0;
            lane_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            load_q  <= load_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            lane_q  <= lane_d;
        end
    end

    // Stall is combinational but forced low while reset is asserted
    assign stall           = reset & stall_c;
    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_be    = be_q;
    assign dmem.dmem_wdata = wdata_q;
    assign readdata_out    = rdata_q;
    assign mem_err         = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (built with MAX_WAIT=4, CNT_W=3).
module tb_mem_access_stage;

    logic        clk;
    logic        reset;
    logic        valid_in;
    logic        memread_in;
    logic        memwrite_in;
    logic [2:0]  funct3_in;
    logic [31:0] addr_in;
    logic [31:0] wdata_in;
    logic [31:0] readdata_out;
    logic        stall;
    logic        mem_err;

    int total;
    int bad;

    mem_access_stage_if dmem_bus ();

    mem_access_stage #(.MAX_WAIT(4), .CNT_W(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_in     (valid_in),
        .memread_in   (memread_in),
        .memwrite_in  (memwrite_in),
        .funct3_in    (funct3_in),
        .addr_in      (addr_in),
        .wdata_in     (wdata_in),
        .dmem         (dmem_bus),
        .readdata_out (readdata_out),
        .stall        (stall),
        .mem_err      (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_in    = 1'b0;
        memread_in  = 1'b0;
        memwrite_in = 1'b0;
        funct3_in   = 3'b000;
        addr_in     = 32'h0;
        wdata_in    = 32'h0;
    endtask

    // One complete access: issue, hold for 'waits' un-acked BUSY cycles, ack, then DONE.
    task automatic do_access(input string tag, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd, input int waits,
                             input logic [31:0] rd, input logic [31:0] exp_addr,
                             input logic [3:0] exp_be, input logic [31:0] exp_wd,
                             input logic [31:0] exp_out);
        valid_in    = 1'b1;
        memread_in  = ~wr;
        memwrite_in = wr;
        funct3_in   = f3;
        addr_in     = a;
        wdata_in    = wd;
        #1;
        chk({tag, ".issue_stall"}, 32'(stall), 32'd1);
        chk({tag, ".issue_req"}, 32'(dmem_bus.dmem_req), 32'd0);
        tick();
        for (int i = 0; i <= waits; i++) begin
            chk({tag, ".busy_stall"}, 32'(stall), 32'd1);
            chk({tag, ".busy_req"}, 32'(dmem_bus.dmem_req), 32'd1);
            chk({tag, ".we"}, 32'(dmem_bus.dmem_we), 32'(wr));
            chk({tag, ".addr"}, dmem_bus.dmem_addr, exp_addr);
            chk({tag, ".be"}, 32'(dmem_bus.dmem_be), 32'(exp_be));
            chk({tag, ".wdata"}, dmem_bus.dmem_wdata, exp_wd);
            chk({tag, ".busy_err"}, 32'(mem_err), 32'd0);
            if (i == waits) begin
                dmem_bus.dmem_ack   = 1'b1;
                dmem_bus.dmem_rdata = rd;
            end
            tick();
        end
        dmem_bus.dmem_ack   = 1'b0;
        dmem_bus.dmem_rdata = 32'h0;
        idle_inputs();
        #1;
        chk({tag, ".done_stall"}, 32'(stall), 32'd0);
        chk({tag, ".done_req"}, 32'(dmem_bus.dmem_req), 32'd0);
        chk({tag, ".done_err"}, 32'(mem_err), 32'd0);
        chk({tag, ".readdata"}, readdata_out, exp_out);
        tick();
        chk({tag, ".idle_stall"}, 32'(stall), 32'd0);
        chk({tag, ".idle_req"}, 32'(dmem_bus.dmem_req), 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        dmem_bus.dmem_ack   = 1'b0;
        dmem_bus.dmem_rdata = 32'h0;
        idle_inputs();

        // Reset state, with a valid load presented to prove stall is held low
        #2;
        reset     = 1'b0;
        valid_in  = 1'b1;
        memread_in = 1'b1;
        funct3_in = 3'b010;
        addr_in   = 32'h100;
        #1;
        chk("rst.stall", 32'(stall), 32'd0);
        chk("rst.req", 32'(dmem_bus.dmem_req), 32'd0);
        chk("rst.we", 32'(dmem_bus.dmem_we), 32'd0);
        chk("rst.addr", dmem_bus.dmem_addr, 32'h0);
        chk("rst.be", 32'(dmem_bus.dmem_be), 32'h0);
        chk("rst.wdata", dmem_bus.dmem_wdata, 32'h0);
        chk("rst.readdata", readdata_out, 32'h0);
        chk("rst.err", 32'(mem_err), 32'd0);
        idle_inputs();
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("post_rst.stall", 32'(stall), 32'd0);

        do_access("lw",  1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF,
                  32'h100, 4'b1111, 32'h0, 32'hDEADBEEF);
        do_access("lb",  1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80112233,
                  32'h100, 4'b1000, 32'h0, 32'hFFFFFF80);
        do_access("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 0, 32'h80112233,
                  32'h100, 4'b1000, 32'h0, 32'h00000080);
        do_access("lhu", 1'b0, 3'b101, 32'h102, 32'h0, 0, 32'h80112233,
                  32'h100, 4'b1100, 32'h0, 32'h00008011);
        do_access("lh",  1'b0, 3'b001, 32'h102, 32'h0, 1, 32'h80112233,
                  32'h100, 4'b1100, 32'h0, 32'hFFFF8011);
        do_access("lh_lo", 1'b0, 3'b001, 32'h200, 32'h0, 0, 32'h80112233,
                  32'h200, 4'b0011, 32'h0, 32'h00002233);
        do_access("sb",  1'b1, 3'b000, 32'h101, 32'h000000A5, 0, 32'hFFFFFFFF,
                  32'h100, 4'b0010, 32'hA5A5A5A5, 32'h00002233);
        do_access("sh",  1'b1, 3'b001, 32'h102, 32'h1234ABCD, 3, 32'hFFFFFFFF,
                  32'h100, 4'b1100, 32'hABCDABCD, 32'h00002233);
        do_access("lw2", 1'b0, 3'b010, 32'h104, 32'h0, 2, 32'h13579BDF,
                  32'h104, 4'b1111, 32'h0, 32'h13579BDF);

        // Misaligned word load
`ifdef MISALIGN_TRAP_EN
        valid_in   = 1'b1;
        memread_in = 1'b1;
        funct3_in  = 3'b010;
        addr_in    = 32'h101;
        #1;
        chk("lw_mis.stall", 32'(stall), 32'd0);
        tick();
        idle_inputs();
        #1;
        chk("lw_mis.req", 32'(dmem_bus.dmem_req), 32'd0);
        chk("lw_mis.err", 32'(mem_err), 32'd1);
        chk("lw_mis.readdata", readdata_out, 32'h0);
        tick();
        chk("lw_mis.err_clr", 32'(mem_err), 32'd0);
        chk("lw_mis.req2", 32'(dmem_bus.dmem_req), 32'd0);
`else
        do_access("lw_mis", 1'b0, 3'b010, 32'h101, 32'h0, 1, 32'hCAFEF00D,
                  32'h100, 4'b1111, 32'h0, 32'hCAFEF00D);
        do_access("lh_mis", 1'b0, 3'b001, 32'h103, 32'h0, 0, 32'h80112233,
                  32'h100, 4'b1100, 32'h0, 32'hFFFF8011);
`endif

        // Timeout: no ack for MAX_WAIT=4 BUSY cycles
        valid_in   = 1'b1;
        memread_in = 1'b1;
        funct3_in  = 3'b010;
        addr_in    = 32'h200;
        #1;
        chk("to.issue_stall", 32'(stall), 32'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("to.busy_req", 32'(dmem_bus.dmem_req), 32'd1);
            chk("to.busy_stall", 32'(stall), 32'd1);
            chk("to.busy_err", 32'(mem_err), 32'd0);
            tick();
        end
        idle_inputs();
        #1;
        chk("to.done_req", 32'(dmem_bus.dmem_req), 32'd0);
        chk("to.done_err", 32'(mem_err), 32'd1);
        chk("to.done_readdata", readdata_out, 32'h0);
        chk("to.done_stall", 32'(stall), 32'd0);
        tick();
        chk("to.err_clr", 32'(mem_err), 32'd0);
        chk("to.idle_stall", 32'(stall), 32'd0);

        do_access("lw3", 1'b0, 3'b010, 32'h300, 32'h0, 0, 32'h2468ACE0,
                  32'h300, 4'b1111, 32'h0, 32'h2468ACE0);

        // Reset while BUSY, then a stray ack after release
        valid_in   = 1'b1;
        memread_in = 1'b1;
        funct3_in  = 3'b010;
        addr_in    = 32'h304;
        wdata_in   = 32'h55AA55AA;
        tick();
        chk("rb.busy_req", 32'(dmem_bus.dmem_req), 32'd1);
        chk("rb.busy_wdata", dmem_bus.dmem_wdata, 32'h55AA55AA);
        reset = 1'b0;
        #1;
        chk("rb.req", 32'(dmem_bus.dmem_req), 32'd0);
        chk("rb.addr", dmem_bus.dmem_addr, 32'h0);
        chk("rb.be", 32'(dmem_bus.dmem_be), 32'h0);
        chk("rb.wdata", dmem_bus.dmem_wdata, 32'h0);
        chk("rb.readdata", readdata_out, 32'h0);
        chk("rb.stall", 32'(stall), 32'd0);
        idle_inputs();
        tick();
        reset = 1'b1;
        tick();
        dmem_bus.dmem_ack   = 1'b1;
        dmem_bus.dmem_rdata = 32'hFFFFFFFF;
        tick();
        dmem_bus.dmem_ack   = 1'b0;
        dmem_bus.dmem_rdata = 32'h0;
        #1;
        chk("rb.late_req", 32'(dmem_bus.dmem_req), 32'd0);
        chk("rb.late_readdata", readdata_out, 32'h0);
        chk("rb.late_stall", 32'(stall), 32'd0);
        chk("rb.late_err", 32'(mem_err), 32'd0);
        tick();
        chk("rb.final_readdata", readdata_out, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
